// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction, holds it until retired.
// Latency: 3 cycles per instruction with zero-wait memory (request, data, retire).
// Backpressure: imem_ready/imem_rvalid/instr_ready low each stretch their state by one cycle.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] instret,
  output logic        fetch_fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instret_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;
  logic [31:0] next_pc;
  logic        retire;
  logic        capture;

  // Next-PC selection for the retiring instruction; 11 is reserved and behaves as PC+4.
  always_comb begin
    next_pc = pc_q + 32'd4;
    case (PCSrc)
      2'b01:   next_pc = pc_q + ImmExt;
      2'b10:   next_pc = ALUResult & ~32'd1;
      default: next_pc = pc_q + 32'd4;
    endcase
  end

  assign retire  = (state == S_HOLD) && instr_ready;
  assign capture = (state == S_WAIT) && imem_rvalid;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and handshake outputs; a misaligned target parks the unit in S_FAULT.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_nxt = (next_pc[1:0] == 2'b00) ? S_REQ : S_FAULT;
        end
      end
      default: begin
        state_nxt = S_FAULT;
      end
    endcase
  end

  // Architectural state: captured word, PC, retire counter and the sticky fault record.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      instret_q    <= 32'd0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      if (capture) begin
        instr_q <= imem_rdata;
      end
      if (retire) begin
        instret_q <= instret_q + 32'd1;
        instr_q   <= NOP_INSTR;
        if (next_pc[1:0] == 2'b00) begin
          pc_q <= next_pc;
        end else begin
          fault_q      <= 1'b1;
          fault_addr_q <= next_pc;
        end
      end
    end
  end

  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + 32'd4;
  assign Instr       = instr_q;
  assign instret     = instret_q;
  assign fetch_fault = fault_q;
  assign fault_addr  = fault_addr_q;

endmodule
